// File: rtl/slot_payout_controller.sv
// Slot machine payout controller: charges a bet on press, freezes the reels on release,
// classifies the combination and applies a saturating payout to the credit balance.
module slot_payout_controller #(
    parameter int unsigned CREDIT_W    = 16,
    parameter int unsigned INIT_CREDIT = 1000,
    parameter int unsigned BET         = 10,
    parameter int unsigned PAIR_PAY    = 50,
    parameter int unsigned TRIPLE_PAY  = 500,
    parameter int unsigned JACKPOT_PAY = 5000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                button_press,
    input  logic [2:0]          rng1,
    input  logic [2:0]          rng2,
    input  logic [2:0]          rng3,
    output logic [2:0]          reel1,
    output logic [2:0]          reel2,
    output logic [2:0]          reel3,
    output logic [CREDIT_W-1:0] credit,
    output logic [CREDIT_W-1:0] last_win,
    output logic [1:0]          result,
    output logic                win_valid,
    output logic                spinning,
    output logic                no_credit
);

    localparam int unsigned SUM_W = CREDIT_W + 1;
    localparam logic [SUM_W-1:0] CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [2:0] JACKPOT_SYM = 3'b111;

    localparam logic [1:0] RES_NONE    = 2'd0;
    localparam logic [1:0] RES_PAIR    = 2'd1;
    localparam logic [1:0] RES_TRIPLE  = 2'd2;
    localparam logic [1:0] RES_JACKPOT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SPIN,
        S_EVAL,
        S_PAY
    } state_t;

    state_t              r_state;
    logic                r_btn_q;
    logic [2:0]          r_reel1;
    logic [2:0]          r_reel2;
    logic [2:0]          r_reel3;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_last_win;
    logic [1:0]          r_result;
    logic                r_win_valid;
    logic                r_spinning;
    logic                r_no_credit;

    logic                w_press;
    logic                w_can_bet;
    logic                w_all_eq;
    logic                w_any_pair;
    logic [1:0]          w_category;
    logic [CREDIT_W-1:0] w_payout;
    logic [SUM_W-1:0]    w_sum;
    logic [CREDIT_W-1:0] w_credit_sat;

    assign w_press   = button_press & ~r_btn_q;
    assign w_can_bet = (r_credit >= CREDIT_W'(BET));

    // Classification works on the latched reels, so it is stable throughout EVAL.
    assign w_all_eq   = (r_reel1 == r_reel2) && (r_reel2 == r_reel3);
    assign w_any_pair = (r_reel1 == r_reel2) || (r_reel2 == r_reel3) || (r_reel1 == r_reel3);

    always_comb begin
        w_category = RES_NONE;
        w_payout   = '0;
        if (w_all_eq && (r_reel1 == JACKPOT_SYM)) begin
            w_category = RES_JACKPOT;
            w_payout   = CREDIT_W'(JACKPOT_PAY);
        end else if (w_all_eq) begin
            w_category = RES_TRIPLE;
            w_payout   = CREDIT_W'(TRIPLE_PAY);
        end else if (w_any_pair) begin
            w_category = RES_PAIR;
            w_payout   = CREDIT_W'(PAIR_PAY);
        end
    end

    // One extra bit catches the carry so the balance clamps instead of wrapping.
    assign w_sum        = {1'b0, r_credit} + {1'b0, r_last_win};
    assign w_credit_sat = (w_sum > CREDIT_MAX) ? CREDIT_MAX[CREDIT_W-1:0] : w_sum[CREDIT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_btn_q     <= 1'b0;
            r_reel1     <= '0;
            r_reel2     <= '0;
            r_reel3     <= '0;
            r_credit    <= CREDIT_W'(INIT_CREDIT);
            r_last_win  <= '0;
            r_result    <= RES_NONE;
            r_win_valid <= 1'b0;
            r_spinning  <= 1'b0;
            r_no_credit <= 1'b0;
        end else begin
            r_btn_q     <= button_press;
            r_win_valid <= 1'b0;
            r_no_credit <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_press) begin
                        if (w_can_bet) begin
                            r_credit   <= r_credit - CREDIT_W'(BET);
                            r_spinning <= 1'b1;
                            r_state    <= S_SPIN;
                        end else begin
                            r_no_credit <= 1'b1;
                        end
                    end
                end
                S_SPIN: begin
                    if (!button_press) begin
                        r_reel1    <= rng1;
                        r_reel2    <= rng2;
                        r_reel3    <= rng3;
                        r_spinning <= 1'b0;
                        r_state    <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    r_result   <= w_category;
                    r_last_win <= w_payout;
                    r_state    <= S_PAY;
                end
                S_PAY: begin
                    r_credit    <= w_credit_sat;
                    r_win_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign reel1     = r_reel1;
    assign reel2     = r_reel2;
    assign reel3     = r_reel3;
    assign credit    = r_credit;
    assign last_win  = r_last_win;
    assign result    = r_result;
    assign win_valid = r_win_valid;
    assign spinning  = r_spinning;
    assign no_credit = r_no_credit;

endmodule

// File: tb/tb_slot_payout_controller.sv
// Bench for slot_payout_controller: three instances (normal, starved, near-saturation credit)
// share one stimulus stream and are checked against a per-spin reference model.
module tb_slot_payout_controller;

    localparam int NI      = 3;
    localparam int BET     = 10;
    localparam int MAX_CR  = 65535;

    logic clk = 1'b0;
    logic reset;
    logic button_press;
    logic [2:0] rng1, rng2, rng3;

    logic [NI-1:0][2:0][2:0] reel_o;
    logic [NI-1:0][15:0]     credit_o;
    logic [NI-1:0][15:0]     last_win_o;
    logic [NI-1:0][1:0]      result_o;
    logic [NI-1:0]           win_valid_o;
    logic [NI-1:0]           spinning_o;
    logic [NI-1:0]           no_credit_o;

    int errors = 0;
    int checks = 0;

    int init_cr[NI] = '{1000, 5, 65530};
    int exp_credit[NI];
    int exp_last[NI];
    int exp_result[NI];
    int exp_reel[NI][3];

    always #5 clk = ~clk;

    slot_payout_controller #(.INIT_CREDIT(1000)) u_dut0 (
        .clk(clk), .reset(reset), .button_press(button_press),
        .rng1(rng1), .rng2(rng2), .rng3(rng3),
        .reel1(reel_o[0][0]), .reel2(reel_o[0][1]), .reel3(reel_o[0][2]),
        .credit(credit_o[0]), .last_win(last_win_o[0]), .result(result_o[0]),
        .win_valid(win_valid_o[0]), .spinning(spinning_o[0]), .no_credit(no_credit_o[0])
    );

    slot_payout_controller #(.INIT_CREDIT(5)) u_dut1 (
        .clk(clk), .reset(reset), .button_press(button_press),
        .rng1(rng1), .rng2(rng2), .rng3(rng3),
        .reel1(reel_o[1][0]), .reel2(reel_o[1][1]), .reel3(reel_o[1][2]),
        .credit(credit_o[1]), .last_win(last_win_o[1]), .result(result_o[1]),
        .win_valid(win_valid_o[1]), .spinning(spinning_o[1]), .no_credit(no_credit_o[1])
    );

    slot_payout_controller #(.INIT_CREDIT(65530)) u_dut2 (
        .clk(clk), .reset(reset), .button_press(button_press),
        .rng1(rng1), .rng2(rng2), .rng3(rng3),
        .reel1(reel_o[2][0]), .reel2(reel_o[2][1]), .reel3(reel_o[2][2]),
        .credit(credit_o[2]), .last_win(last_win_o[2]), .result(result_o[2]),
        .win_valid(win_valid_o[2]), .spinning(spinning_o[2]), .no_credit(no_credit_o[2])
    );

    // Reference: histogram of reel symbols decides the category, payout follows from it.
    function automatic int classify(input int r0, input int r1, input int r2, output int pay);
        int cnt[8];
        int mx;
        int cat;
        foreach (cnt[v]) cnt[v] = 0;
        cnt[r0]++; cnt[r1]++; cnt[r2]++;
        mx = 0;
        foreach (cnt[v]) if (cnt[v] > mx) mx = cnt[v];
        if (mx == 3)      cat = (r0 == 7) ? 3 : 2;
        else if (mx == 2) cat = 1;
        else              cat = 0;
        case (cat)
            3:       pay = 5000;
            2:       pay = 500;
            1:       pay = 50;
            default: pay = 0;
        endcase
        return cat;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            exp_credit[i] = init_cr[i];
            exp_last[i]   = 0;
            exp_result[i] = 0;
            for (int k = 0; k < 3; k++) exp_reel[i][k] = 0;
        end
    endtask

    task automatic randomize_rng();
        rng1 = 3'($urandom_range(0, 7));
        rng2 = 3'($urandom_range(0, 7));
        rng3 = 3'($urandom_range(0, 7));
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (credit_o[i] !== 16'(exp_credit[i]) || last_win_o[i] !== 16'(exp_last[i]) ||
                result_o[i] !== 2'(exp_result[i]) || spinning_o[i] !== 1'b0 ||
                win_valid_o[i] !== 1'b0 || no_credit_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL %s inst%0d credit=%0d/%0d last_win=%0d/%0d result=%0d/%0d spin=%b win=%b noc=%b (want 0 0 0)",
                         tag, i, credit_o[i], exp_credit[i], last_win_o[i], exp_last[i],
                         result_o[i], exp_result[i], spinning_o[i], win_valid_o[i], no_credit_o[i]);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (reel_o[i][k] !== 3'(exp_reel[i][k])) begin
                    errors++;
                    $display("FAIL %s_reel inst%0d reel%0d got %0d want %0d",
                             tag, i, k + 1, reel_o[i][k], exp_reel[i][k]);
                end
            end
        end
    endtask

    // One full press/hold/release/evaluate/pay sequence, checked at every phase.
    task automatic spin(input int r0, input int r1, input int r2, input int hold);
        bit ok[NI];
        int cat, pay;
        @(negedge clk);
        button_press = 1'b1;
        randomize_rng();
        for (int i = 0; i < NI; i++) ok[i] = (exp_credit[i] >= BET);
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            if (ok[i]) exp_credit[i] -= BET;
            checks++;
            if (credit_o[i] !== 16'(exp_credit[i]) || spinning_o[i] !== ok[i] || no_credit_o[i] !== !ok[i]) begin
                errors++;
                $display("FAIL press inst%0d credit=%0d want %0d spinning=%b want %b no_credit=%b want %b",
                         i, credit_o[i], exp_credit[i], spinning_o[i], ok[i], no_credit_o[i], !ok[i]);
            end
        end
        for (int c = 1; c < hold; c++) begin
            randomize_rng();
            @(posedge clk); @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (credit_o[i] !== 16'(exp_credit[i]) || spinning_o[i] !== ok[i] || no_credit_o[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL hold inst%0d cycle%0d credit=%0d want %0d spinning=%b want %b no_credit=%b want 0",
                             i, c, credit_o[i], exp_credit[i], spinning_o[i], ok[i], no_credit_o[i]);
                end
            end
        end
        button_press = 1'b0;
        rng1 = 3'(r0); rng2 = 3'(r1); rng3 = 3'(r2);
        @(posedge clk); @(negedge clk);
        randomize_rng();
        cat = classify(r0, r1, r2, pay);
        for (int i = 0; i < NI; i++) begin
            if (ok[i]) begin
                exp_reel[i][0] = r0; exp_reel[i][1] = r1; exp_reel[i][2] = r2;
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (reel_o[i][k] !== 3'(exp_reel[i][k])) begin
                    errors++;
                    $display("FAIL latch inst%0d reel%0d got %0d want %0d", i, k + 1, reel_o[i][k], exp_reel[i][k]);
                end
            end
            checks++;
            if (spinning_o[i] !== 1'b0 || win_valid_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL release inst%0d spinning=%b win_valid=%b want 0 0", i, spinning_o[i], win_valid_o[i]);
            end
        end
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            if (ok[i]) begin
                exp_result[i] = cat;
                exp_last[i]   = pay;
            end
            checks++;
            if (result_o[i] !== 2'(exp_result[i]) || last_win_o[i] !== 16'(exp_last[i]) || win_valid_o[i] !== 1'b0) begin
                errors++;
                $display("FAIL eval inst%0d result=%0d want %0d last_win=%0d want %0d win_valid=%b want 0",
                         i, result_o[i], exp_result[i], last_win_o[i], exp_last[i], win_valid_o[i]);
            end
        end
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            if (ok[i]) begin
                exp_credit[i] += exp_last[i];
                if (exp_credit[i] > MAX_CR) exp_credit[i] = MAX_CR;
            end
            checks++;
            if (credit_o[i] !== 16'(exp_credit[i]) || win_valid_o[i] !== ok[i]) begin
                errors++;
                $display("FAIL pay inst%0d credit=%0d want %0d win_valid=%b want %b",
                         i, credit_o[i], exp_credit[i], win_valid_o[i], ok[i]);
            end
        end
        @(posedge clk); @(negedge clk);
        check_idle_outputs("after_pay");
    endtask

    task automatic test_reset();
        reset = 1'b1;
        button_press = 1'b0;
        randomize_rng();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset_held");
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        check_idle_outputs("reset_released");
    endtask

    task automatic test_directed();
        int tbl[4][3] = '{'{7, 7, 7}, '{3, 3, 5}, '{2, 2, 2}, '{1, 4, 6}};
        for (int t = 0; t < 4; t++) spin(tbl[t][0], tbl[t][1], tbl[t][2], 1);
    endtask

    task automatic test_long_hold();
        spin(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 20);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++)
            spin(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(1, 4)));
    endtask

    task automatic test_reset_mid_spin();
        @(negedge clk);
        button_press = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (spinning_o[0] !== 1'b1 || credit_o[0] !== 16'(exp_credit[0] - BET)) begin
            errors++;
            $display("FAIL mid_spin_pre spinning=%b want 1 credit=%0d want %0d",
                     spinning_o[0], credit_o[0], exp_credit[0] - BET);
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_idle_outputs("async_reset");
        button_press = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); @(negedge clk);
            check_idle_outputs("post_reset_quiet");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_long_hold();
        test_random();
        test_reset_mid_spin();
        test_directed();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
